// File: rtl/altsyncram_stream_reader.sv
// rtl/altsyncram_stream_reader.sv - burst reader from an altsyncram read port into a ready/valid stream
//
// Reads `length` consecutive words starting at `start_address` from a RAM
// read port. Each word is then presented on a stream interface. The returned
// words pass through a small first-word-fall-through buffer. Reads are only
// issued while the buffer is guaranteed to have room for every read already
// in flight.
//
// Ports:
//   clock0         sole clock, rising edge
//   sclr           synchronous active-high reset
//   start          one-cycle burst request, sampled only in IDLE
//   start_address  first word address, sampled with start
//   length         burst word count, sampled with start (0 gives an immediate done)
//   busy           high while a burst is active
//   done           one-cycle pulse when the burst completes
//   mem_address    RAM read address
//   mem_rden       RAM read enable
//   mem_q          RAM read data, valid READ_LATENCY cycles after mem_rden
//   tdata/tvalid   stream data and valid
//   tready         stream sink ready
//   tlast          final beat of the burst
module altsyncram_stream_reader #(
    parameter int WIDTH        = 8,
    parameter int WIDTHAD      = 10,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic               clock0,
    input  logic               sclr,
    input  logic               start,
    input  logic [WIDTHAD-1:0] start_address,
    input  logic [WIDTHAD:0]   length,
    output logic               busy,
    output logic               done,
    output logic [WIDTHAD-1:0] mem_address,
    output logic               mem_rden,
    input  logic [WIDTH-1:0]   mem_q,
    output logic [WIDTH-1:0]   tdata,
    output logic               tvalid,
    input  logic               tready,
    output logic               tlast
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // Wide enough for in-flight + occupancy + one spare bit for the compare.
    localparam int CW = PW + 2;
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(FIFO_DEPTH);

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_latency
            $error("altsyncram_stream_reader: READ_LATENCY must be 1 or 2");
        end
        if (FIFO_DEPTH < READ_LATENCY + 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("altsyncram_stream_reader: FIFO_DEPTH must be a power of two >= READ_LATENCY+1");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                  state;
    logic [WIDTHAD:0]        remaining;
    logic [READ_LATENCY-1:0] tok_valid;
    logic [READ_LATENCY-1:0] tok_last;

    logic [WIDTH-1:0]        fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   fifo_last;
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [PW:0]             count;

    logic [CW-1:0]           in_flight;
    logic                    push;
    logic                    pop;
    logic                    credit_ok;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            in_flight = in_flight + CW'(tok_valid[i]);
        end
    end

    assign push   = tok_valid[READ_LATENCY-1];
    assign tvalid = (count != '0);
    assign pop    = tvalid && tready;
    assign tdata  = tvalid ? fifo_data[rd_ptr] : '0;
    assign tlast  = tvalid && fifo_last[rd_ptr];

    // Every token in flight will land in the buffer. A beat leaving this
    // cycle frees a slot. Issuing only below that bound means the buffer
    // can never overflow.
    assign credit_ok = (in_flight + CW'(count)) < (CW'(FIFO_DEPTH) + CW'(pop));
    assign mem_rden  = (state == S_RUN) && credit_ok;

    always_ff @(posedge clock0) begin
        if (sclr) begin
            state       <= S_IDLE;
            remaining   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_address <= '0;
            tok_valid   <= '0;
            tok_last    <= '0;
            fifo_last   <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            done <= 1'b0;

            tok_valid[0] <= mem_rden;
            tok_last[0]  <= mem_rden && (remaining == (WIDTHAD + 1)'(1));
            for (int i = 1; i < READ_LATENCY; i++) begin
                tok_valid[i] <= tok_valid[i-1];
                tok_last[i]  <= tok_last[i-1];
            end

            if (push) begin
                fifo_last[wr_ptr] <= tok_last[READ_LATENCY-1];
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + (PW + 1)'(push) - (PW + 1)'(pop);

            if (mem_rden) begin
                mem_address <= mem_address + WIDTHAD'(1);
                remaining   <= remaining - (WIDTHAD + 1)'(1);
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            mem_address <= start_address;
                            remaining   <= length;
                            busy        <= 1'b1;
                            state       <= S_RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (mem_rden && remaining == (WIDTHAD + 1)'(1)) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop && tlast) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Storage needs no reset: tdata is gated by tvalid.
    always_ff @(posedge clock0) begin
        if (push) begin
            fifo_data[wr_ptr] <= mem_q;
        end
    end

    always_ff @(posedge clock0) begin
        if (!sclr && push) begin
            assert (count != FULL_COUNT)
            else $error("altsyncram_stream_reader: write to full output buffer");
        end
    end

endmodule

// File: tb/tb_altsyncram_stream_reader.sv
// tb/tb_altsyncram_stream_reader.sv - directed self-checking bench for altsyncram_stream_reader
module tb_altsyncram_stream_reader;

    logic        clk = 1'b0;
    logic        sclr, start_a, start_b, tready;
    logic [9:0]  saddr;
    logic [10:0] len;

    logic        busy_a, done_a, rden_a, tvalid_a, tlast_a;
    logic [9:0]  addr_a;
    logic [7:0]  q_a, tdata_a;

    logic        busy_b, done_b, rden_b, tvalid_b, tlast_b;
    logic [3:0]  addr_b;
    logic [7:0]  q_b, r1_b, tdata_b;

    int tests = 0;
    int fails = 0;

    altsyncram_stream_reader #(.WIDTH(8), .WIDTHAD(10), .READ_LATENCY(1), .FIFO_DEPTH(4)) dut_a (
        .clock0(clk), .sclr(sclr), .start(start_a), .start_address(saddr), .length(len),
        .busy(busy_a), .done(done_a), .mem_address(addr_a), .mem_rden(rden_a), .mem_q(q_a),
        .tdata(tdata_a), .tvalid(tvalid_a), .tready(tready), .tlast(tlast_a)
    );

    altsyncram_stream_reader #(.WIDTH(8), .WIDTHAD(4), .READ_LATENCY(2), .FIFO_DEPTH(4)) dut_b (
        .clock0(clk), .sclr(sclr), .start(start_b), .start_address(saddr[3:0]), .length(len[4:0]),
        .busy(busy_b), .done(done_b), .mem_address(addr_b), .mem_rden(rden_b), .mem_q(q_b),
        .tdata(tdata_b), .tvalid(tvalid_b), .tready(tready), .tlast(tlast_b)
    );

    always #5 clk = ~clk;

    // RAM A: RAM[i] = i, unregistered output (one cycle latency).
    always @(posedge clk) begin
        if (rden_a) q_a <= addr_a[7:0];
    end

    // RAM B: RAM[i] = {A, i}, registered output (two cycle latency).
    always @(posedge clk) begin
        if (rden_b) r1_b <= {4'hA, addr_b};
        q_b <= r1_b;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        sclr = 1'b1; start_a = 1'b1; start_b = 1'b1; saddr = 10'h003; len = 11'd5; tready = 1'b1;
        step;
        start_a = 1'b0; start_b = 1'b0;
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        tests++; if (done_a !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done_a); end
        tests++; if (rden_a !== 1'b0) begin fails++; $display("FAIL reset_rden: got %b want 0", rden_a); end
        tests++; if (addr_a !== 10'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", addr_a); end
        tests++; if (tvalid_a !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b want 0", tvalid_a); end
        tests++; if (tlast_a !== 1'b0) begin fails++; $display("FAIL reset_tlast: got %b want 0", tlast_a); end
        tests++; if (tdata_a !== 8'h0) begin fails++; $display("FAIL reset_tdata: got %h want 0", tdata_a); end
        tests++; if (busy_b !== 1'b0 || tvalid_b !== 1'b0) begin fails++; $display("FAIL reset_b: got busy=%b tvalid=%b want 0 0", busy_b, tvalid_b); end
        sclr = 1'b0;
        step;
        tests++; if (busy_a !== 1'b0 || rden_a !== 1'b0) begin fails++; $display("FAIL reset_priority: got busy=%b rden=%b want 0 0", busy_a, rden_a); end
    endtask

    task automatic test_basic;
        logic       e_rden, e_valid, e_last, e_done, e_busy;
        logic [7:0] e_data;
        logic [9:0] e_addr;
        tready = 1'b1; saddr = 10'h010; len = 11'd4; start_a = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step;
            start_a = (c == 2);
            if (c == 2) begin saddr = 10'h099; len = 11'd7; end
            e_rden  = (c >= 1 && c <= 4);
            e_valid = (c >= 3 && c <= 6);
            e_data  = e_valid ? 8'(8'h10 + c - 3) : 8'h00;
            e_last  = (c == 6);
            e_done  = (c == 7);
            e_busy  = (c <= 6);
            e_addr  = 10'(10'h010 + c - 1);
            tests++; if (rden_a !== e_rden) begin fails++; $display("FAIL basic_rden c%0d: got %b want %b", c, rden_a, e_rden); end
            if (e_rden) begin
                tests++; if (addr_a !== e_addr) begin fails++; $display("FAIL basic_addr c%0d: got %h want %h", c, addr_a, e_addr); end
            end
            tests++; if (tvalid_a !== e_valid) begin fails++; $display("FAIL basic_tvalid c%0d: got %b want %b", c, tvalid_a, e_valid); end
            tests++; if (tdata_a !== e_data) begin fails++; $display("FAIL basic_tdata c%0d: got %h want %h", c, tdata_a, e_data); end
            tests++; if (tlast_a !== e_last) begin fails++; $display("FAIL basic_tlast c%0d: got %b want %b", c, tlast_a, e_last); end
            tests++; if (done_a !== e_done) begin fails++; $display("FAIL basic_done c%0d: got %b want %b", c, done_a, e_done); end
            tests++; if (busy_a !== e_busy) begin fails++; $display("FAIL basic_busy c%0d: got %b want %b", c, busy_a, e_busy); end
        end
        start_a = 1'b0;
    endtask

    task automatic test_zero_length;
        int seen = 0;
        int extra_done = 0;
        saddr = 10'h005; len = 11'd0; start_a = 1'b1;
        step;
        start_a = 1'b0;
        tests++; if (done_a !== 1'b1) begin fails++; $display("FAIL zero_done: got %b want 1", done_a); end
        for (int c = 0; c < 6; c++) begin
            if (busy_a || rden_a || tvalid_a) seen++;
            step;
            if (done_a) extra_done++;
        end
        tests++; if (seen != 0) begin fails++; $display("FAIL zero_activity: got %0d active cycles want 0", seen); end
        tests++; if (extra_done != 0) begin fails++; $display("FAIL zero_extra_done: got %0d want 0", extra_done); end
    endtask

    task automatic test_back_to_back;
        logic       got_last = 1'b0;
        logic       got_beat = 1'b0;
        logic [7:0] b_data = 8'h00;
        logic       b_last = 1'b0;
        tready = 1'b1; saddr = 10'h030; len = 11'd2; start_a = 1'b1;
        step;
        start_a = 1'b0;
        for (int k = 0; k < 20 && !got_last; k++) begin
            if (tvalid_a && tlast_a) got_last = 1'b1;
            else step;
        end
        tests++; if (!got_last) begin fails++; $display("FAIL b2b_timeout: got no tlast want tlast within 20 cycles"); end
        step;
        tests++; if (done_a !== 1'b1 || busy_a !== 1'b0) begin fails++; $display("FAIL b2b_done: got done=%b busy=%b want 1 0", done_a, busy_a); end
        saddr = 10'h050; len = 11'd1; start_a = 1'b1;
        step;
        start_a = 1'b0;
        tests++; if (busy_a !== 1'b1 || rden_a !== 1'b1 || addr_a !== 10'h050) begin
            fails++; $display("FAIL b2b_restart: got busy=%b rden=%b addr=%h want 1 1 050", busy_a, rden_a, addr_a);
        end
        for (int k = 0; k < 20; k++) begin
            if (tvalid_a && tready && !got_beat) begin got_beat = 1'b1; b_data = tdata_a; b_last = tlast_a; end
            if (done_a) break;
            step;
        end
        tests++; if (!got_beat || b_data !== 8'h50 || b_last !== 1'b1) begin
            fails++; $display("FAIL b2b_beat: got beat=%b data=%h last=%b want 1 50 1", got_beat, b_data, b_last);
        end
    endtask

    task automatic test_reset_mid_burst;
        int beats = 0;
        int bad_after = 0;
        int dones = 0;
        int n = 0;
        logic [7:0] d0 = 8'h00, d1 = 8'h00;
        logic       l0 = 1'b0, l1 = 1'b0;
        tready = 1'b1; saddr = 10'h020; len = 11'd8; start_a = 1'b1;
        step;
        start_a = 1'b0;
        for (int k = 0; k < 30 && beats < 3; k++) begin
            if (tvalid_a) begin
                tests++; if (tdata_a !== 8'(8'h20 + beats)) begin fails++; $display("FAIL abort_pre_data %0d: got %h want %h", beats, tdata_a, 8'(8'h20 + beats)); end
                beats++;
            end
            if (beats < 3) step;
        end
        step;
        sclr = 1'b1;
        step;
        sclr = 1'b0;
        tests++; if (busy_a !== 1'b0 || done_a !== 1'b0 || rden_a !== 1'b0 || addr_a !== 10'h0 ||
                     tvalid_a !== 1'b0 || tlast_a !== 1'b0 || tdata_a !== 8'h0) begin
            fails++; $display("FAIL abort_zero: got busy=%b done=%b rden=%b addr=%h tvalid=%b tlast=%b tdata=%h want all 0",
                              busy_a, done_a, rden_a, addr_a, tvalid_a, tlast_a, tdata_a);
        end
        for (int k = 0; k < 5; k++) begin
            step;
            if (done_a || tvalid_a || busy_a) bad_after++;
        end
        tests++; if (bad_after != 0) begin fails++; $display("FAIL abort_quiet: got %0d active cycles want 0", bad_after); end
        saddr = 10'h040; len = 11'd2; start_a = 1'b1;
        step;
        start_a = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (tvalid_a && tready) begin
                if (n == 0) begin d0 = tdata_a; l0 = tlast_a; end
                if (n == 1) begin d1 = tdata_a; l1 = tlast_a; end
                n++;
            end
            if (done_a) dones++;
            step;
        end
        tests++; if (n != 2) begin fails++; $display("FAIL abort_restart_count: got %0d beats want 2", n); end
        tests++; if (d0 !== 8'h40 || d1 !== 8'h41) begin fails++; $display("FAIL abort_restart_data: got %h %h want 40 41", d0, d1); end
        tests++; if (l0 !== 1'b0 || l1 !== 1'b1) begin fails++; $display("FAIL abort_restart_last: got %b %b want 0 1", l0, l1); end
        tests++; if (dones != 1) begin fails++; $display("FAIL abort_restart_done: got %0d want 1", dones); end
    endtask

    task automatic test_random_ready;
        int beats = 0;
        int dones = 0;
        logic       prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        logic       prev_last = 1'b0;
        saddr = 10'h100; len = 11'd64; start_a = 1'b1;
        step;
        start_a = 1'b0;
        for (int k = 0; k < 600; k++) begin
            tready = 1'($urandom_range(0, 1));
            if (prev_stall) begin
                tests++; if (tvalid_a !== 1'b1 || tdata_a !== prev_data || tlast_a !== prev_last) begin
                    fails++; $display("FAIL rand_stable k%0d: got v=%b d=%h l=%b want 1 %h %b", k, tvalid_a, tdata_a, tlast_a, prev_data, prev_last);
                end
            end
            if (tvalid_a && tready) begin
                tests++; if (tdata_a !== 8'(beats)) begin fails++; $display("FAIL rand_data beat%0d: got %h want %h", beats, tdata_a, 8'(beats)); end
                tests++; if (tlast_a !== (beats == 63)) begin fails++; $display("FAIL rand_tlast beat%0d: got %b want %b", beats, tlast_a, beats == 63); end
                beats++;
            end
            if (done_a) dones++;
            prev_stall = tvalid_a && !tready;
            prev_data  = tdata_a;
            prev_last  = tlast_a;
            step;
        end
        tready = 1'b1;
        tests++; if (beats != 64) begin fails++; $display("FAIL rand_beats: got %0d want 64", beats); end
        tests++; if (dones != 1) begin fails++; $display("FAIL rand_done: got %0d want 1", dones); end
    endtask

    task automatic test_backpressure;
        int issued = 0;
        int taken = 0;
        int maxout = 0;
        int issued_stall = 0;
        int dones = 0;
        tready = 1'b0; saddr = 10'h003; len = 11'd16; start_b = 1'b1;
        step;
        start_b = 1'b0;
        for (int c = 1; c < 120; c++) begin
            tready = (c > 10);
            #1;
            if (rden_b) begin
                tests++; if (addr_b !== 4'(3 + issued)) begin fails++; $display("FAIL bp_addr %0d: got %h want %h", issued, addr_b, 4'(3 + issued)); end
                issued++;
            end
            if (tvalid_b && tready) begin
                tests++; if (tdata_b !== {4'hA, 4'(3 + taken)} || tlast_b !== (taken == 15)) begin
                    fails++; $display("FAIL bp_beat %0d: got %h/%b want %h/%b", taken, tdata_b, tlast_b, {4'hA, 4'(3 + taken)}, taken == 15);
                end
                taken++;
            end
            if (done_b) dones++;
            if (issued - taken > maxout) maxout = issued - taken;
            if (c == 10) issued_stall = issued;
            step;
        end
        tests++; if (issued_stall != 4) begin fails++; $display("FAIL bp_stall_reads: got %0d want 4", issued_stall); end
        tests++; if (maxout > 4) begin fails++; $display("FAIL bp_outstanding: got %0d want <=4", maxout); end
        tests++; if (issued != 16 || taken != 16) begin fails++; $display("FAIL bp_counts: got reads=%0d beats=%0d want 16 16", issued, taken); end
        tests++; if (dones != 1) begin fails++; $display("FAIL bp_done: got %0d want 1", dones); end
    endtask

    task automatic test_wrap;
        logic [3:0] seen [4];
        int n = 0;
        tready = 1'b1; saddr = 10'h00E; len = 11'd4; start_b = 1'b1;
        step;
        start_b = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (rden_b) begin
                if (n < 4) seen[n] = addr_b;
                n++;
            end
            step;
        end
        tests++; if (n != 4) begin fails++; $display("FAIL wrap_count: got %0d want 4", n); end
        if (n == 4) begin
            tests++; if (seen[0] !== 4'hE || seen[1] !== 4'hF || seen[2] !== 4'h0 || seen[3] !== 4'h1) begin
                fails++; $display("FAIL wrap_addr: got %h %h %h %h want e f 0 1", seen[0], seen[1], seen[2], seen[3]);
            end
        end
    endtask

    initial begin
        sclr = 1'b1; start_a = 1'b0; start_b = 1'b0; tready = 1'b1; saddr = '0; len = '0;
        step;
        test_reset;
        test_basic;
        test_zero_length;
        test_back_to_back;
        test_reset_mid_burst;
        test_random_ready;
        test_backpressure;
        test_wrap;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
